// File: rtl/frame_arbiter_nch.sv
// N-channel frame arbiter: merges NUM_CH valid/ready frame streams into one array stream,
// locking the grant for a whole frame and flagging EOF/length disagreements.
module frame_arbiter_nch #(
    parameter int NUM_CH           = 4,
    parameter int FRAME_DATA_WIDTH = 97,
    parameter int OUT_DATA_WIDTH   = 89,
    parameter int EOF_BIT          = 88,
    parameter int LEN_LSB          = 89,
    parameter int LEN_WIDTH        = 8,
    parameter int BEATS_PER_LEN    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mc_en,
    input  logic [1:0]                         arb_mode,
    input  logic [$clog2(NUM_CH)-1:0]          prio_ch,
    input  logic [NUM_CH-1:0]                  in_valid,
    output logic [NUM_CH-1:0]                  in_ready,
    input  logic [NUM_CH*FRAME_DATA_WIDTH-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_DATA_WIDTH-1:0]          out_data,
    output logic [NUM_CH-1:0]                  grant,
    output logic                               busy,
    output logic                               frame_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = LEN_WIDTH + $clog2(BEATS_PER_LEN) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                      state, state_nxt;
    logic                        start;
    logic [CH_W-1:0]             g_idx, rr_ptr, winner, rr_win, fixed_win, idx;
    logic                        rr_found;
    logic [CNT_W-1:0]            beat_cnt, expected;
    logic [LEN_WIDTH-1:0]        len_reg, len_eff;
    logic [FRAME_DATA_WIDTH-1:0] cur_frame;
    logic                        hs, eof, count_hit, frame_end;

    // Winner selection; only consumed in IDLE, so mode/prio changes never touch a locked frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rr_win    = '0;
        rr_found  = 1'b0;
        fixed_win = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!rr_found && in_valid[idx]) begin
                rr_win   = idx;
                rr_found = 1'b1;
            end
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (in_valid[k]) fixed_win = CH_W'(k);
        end
        case (arb_mode)
            2'b00:   winner = fixed_win;
            2'b10:   winner = (int'(prio_ch) < NUM_CH && in_valid[prio_ch]) ? prio_ch : rr_win;
            default: winner = rr_win;
        endcase
    end

    assign cur_frame = in_data[g_idx*FRAME_DATA_WIDTH +: FRAME_DATA_WIDTH];
    assign busy      = (state == BUSY);
    assign out_valid = |(grant & in_valid);
    assign in_ready  = grant & {NUM_CH{out_ready}};
    assign out_data  = busy ? cur_frame[OUT_DATA_WIDTH-1:0] : '0;
    assign hs        = out_valid & out_ready;
    assign eof       = cur_frame[EOF_BIT];

    // The first beat uses the live len field so single-AXI-beat frames terminate correctly.
    assign len_eff   = (beat_cnt == '0) ? cur_frame[LEN_LSB +: LEN_WIDTH] : len_reg;
    assign expected  = (CNT_W'(len_eff) + CNT_W'(1)) * CNT_W'(BEATS_PER_LEN);
    assign count_hit = (beat_cnt == expected - CNT_W'(1));
    assign frame_end = busy & hs & (eof | count_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (mc_en && |in_valid) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY:    if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            len_reg   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_end & (eof ^ count_hit);
            if (start) begin
                grant <= NUM_CH'(1) << winner;
                g_idx <= winner;
                if (arb_mode != 2'b00)
                    rr_ptr <= (int'(winner) == NUM_CH - 1) ? '0 : winner + CH_W'(1);
            end
            if (hs && beat_cnt == '0) len_reg <= cur_frame[LEN_LSB +: LEN_WIDTH];
            if (frame_end) begin
                beat_cnt <= '0;
                grant    <= '0;
            end else if (hs) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule
